md_issue: RTL and testbench

Pipeline-side front end for the multdiv unit. It sits in the execute stage upstream of the multdiv datapath and its control. It captures a MULT/DIV instruction's operands and destination, then issues a single-cycle ctrl_MULT/ctrl_DIV pulse. It stalls the front of the pipeline until the multdiv unit signals ready, then presents one writeback beat (result, or rstatus code on exception) to the register-file write stage.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_issue_if.sv | 27 ++
 rtl/md_watchdog.sv | 32 +++
 rtl/md_issue.sv | 111 +++++++++++
 tb/tb_md_issue.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared types and constants for the multdiv issue front end
package md_pkg;

    localparam int W            = 32;
    localparam int RD_W         = 5;
    localparam int TIMEOUT      = 40;
    localparam int CNT_W        = 6;
    localparam int RSTATUS_REG  = 30;
    localparam int MUL_EXC_CODE = 4;
    localparam int DIV_EXC_CODE = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    // rstatus value written on an exception, chosen by the latched op type
    function automatic logic [W-1:0] exc_code(input logic is_div);
        return is_div ? W'(DIV_EXC_CODE) : W'(MUL_EXC_CODE);
    endfunction

endpackage

// File: rtl/md_issue_if.sv
// rtl/md_issue_if.sv - operand/control/result bus between the issue front end and multdiv
//
// master (issue side): drives md_opA, md_opB, ctrl_MULT, ctrl_DIV;
//                      receives md_result, md_exception, md_ready
// slave  (multdiv)   : the mirror image
interface md_issue_if;
    import md_pkg::*;

    logic [W-1:0] md_opA;
    logic [W-1:0] md_opB;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] md_result;
    logic         md_exception;
    logic         md_ready;

    modport master (
        output md_opA, md_opB, ctrl_MULT, ctrl_DIV,
        input  md_result, md_exception, md_ready
    );

    modport slave (
        input  md_opA, md_opB, ctrl_MULT, ctrl_DIV,
        output md_result, md_exception, md_ready
    );

endinterface

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - 6-bit busy-cycle counter with clear, enable and timeout hit
//
// clock, reset_n : clock and asynchronous active-low clear
// clr            : zero the count (held during START)
// en             : count up one per cycle (held during BUSY)
// hit            : count has reached TIMEOUT
module md_watchdog
    import md_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // count holds the number of BUSY cycles already completed
    assign hit = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/md_issue.sv
// rtl/md_issue.sv - execute-stage issue front end for the multdiv unit
//
// clock, reset_n         : clock, asynchronous active-low reset
// ex_is_mult, ex_is_div  : instruction in X is MUL / DIV (both high -> MUL)
// ex_opA, ex_opB, ex_rd  : operands and destination from X
// flush                  : kill the in-flight instruction
// md                     : multdiv bus (operands, start pulses, result/exception/ready)
// stall                  : freeze PC and the F/D, D/X latches
// wb_valid, wb_rd, wb_data : single-cycle writeback beat
module md_issue
    import md_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ex_is_mult,
    input  logic            ex_is_div,
    input  logic [W-1:0]    ex_opA,
    input  logic [W-1:0]    ex_opB,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            flush,
    md_issue_if.master      md,
    output logic            stall,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [W-1:0]    wb_data
);

    md_state_t       state;
    logic            is_div_q;
    logic [RD_W-1:0] rd_q;
    logic            wb_pend;
    logic            wd_hit;
    logic            issue_req;

    assign issue_req = ex_is_mult | ex_is_div;

    // The issue cycle must already hold the pipeline, so IDLE stalls straight off the request.
    assign stall = (state == ST_IDLE) ? issue_req
                                      : ((state == ST_START) || (state == ST_BUSY));

    // A flush landing on the DONE cycle still has to cancel the write.
    assign wb_valid = wb_pend & ~flush;

    md_watchdog u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (state == ST_START),
        .en      (state == ST_BUSY),
        .hit     (wd_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            is_div_q     <= 1'b0;
            rd_q         <= '0;
            md.md_opA    <= '0;
            md.md_opB    <= '0;
            md.ctrl_MULT <= 1'b0;
            md.ctrl_DIV  <= 1'b0;
            wb_pend      <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            md.ctrl_MULT <= 1'b0;
            md.ctrl_DIV  <= 1'b0;
            wb_pend      <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            case (state)
                ST_IDLE: begin
                    if (issue_req && !flush) begin
                        md.md_opA    <= ex_opA;
                        md.md_opB    <= ex_opB;
                        rd_q         <= ex_rd;
                        is_div_q     <= ~ex_is_mult;
                        md.ctrl_MULT <= ex_is_mult;
                        md.ctrl_DIV  <= ~ex_is_mult;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    state <= flush ? ST_IDLE : ST_BUSY;
                end
                ST_BUSY: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (md.md_ready || wd_hit) begin
                        state <= ST_DONE;
                        if (md.md_ready && !md.md_exception) begin
                            wb_rd   <= rd_q;
                            wb_data <= md.md_result;
                            wb_pend <= (rd_q != '0);
                        end else begin
                            wb_rd   <= RD_W'(RSTATUS_REG);
                            wb_data <= exc_code(is_div_q);
                            wb_pend <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue.sv
// tb/tb_md_issue.sv - self-checking bench for md_issue
module tb_md_issue;

    localparam int TMO = 40;

    logic        clock;
    logic        reset_n;
    logic        ex_is_mult;
    logic        ex_is_div;
    logic [31:0] ex_opA;
    logic [31:0] ex_opB;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_pass   = 0;
    int op_id    = 0;

    md_issue_if mdif ();

    md_issue dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ex_is_mult (ex_is_mult),
        .ex_is_div  (ex_is_div),
        .ex_opA     (ex_opA),
        .ex_opB     (ex_opB),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .md         (mdif),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall"},   32'(stall), 0);
        check({tag, " ctrlM"},   32'(mdif.ctrl_MULT), 0);
        check({tag, " ctrlD"},   32'(mdif.ctrl_DIV), 0);
        check({tag, " wbv"},     32'(wb_valid), 0);
        check({tag, " wbrd"},    32'(wb_rd), 0);
        check({tag, " wbdata"},  wb_data, 0);
        check({tag, " opA"},     mdif.md_opA, 0);
        check({tag, " opB"},     mdif.md_opB, 0);
    endtask

    task automatic idle_inputs();
        ex_is_mult        = 1'b0;
        ex_is_div         = 1'b0;
        ex_opA            = $urandom;
        ex_opB            = $urandom;
        ex_rd             = 5'($urandom);
        flush             = 1'b0;
        mdif.md_ready     = 1'b0;
        mdif.md_result    = $urandom;
        mdif.md_exception = 1'($urandom);
    endtask

    // One instruction, timeline derived from the issue rules: issue at 0, pulse at 1,
    // BUSY from 2, ready at t gives writeback at t+1, no ready gives writeback after TMO+1 BUSY cycles.
    // rdy < 0 means the multdiv never answers; flc < 0 means no flush.
    task automatic run_op(input bit is_div, input bit both, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rdy, input bit mexc, input int flc);
        bit          eff_div;
        bit          got_ready;
        bit          exc;
        bit          killed;
        int          e_cyc;
        int          last;
        logic [31:0] res;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        string       p;

        op_id++;
        eff_div = is_div && !both;
        if (eff_div) res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        else         res = a * b;
        got_ready = (rdy >= 2) && (rdy <= 2 + TMO);
        e_cyc     = got_ready ? rdy + 1 : 3 + TMO;
        exc       = got_ready ? mexc : 1'b1;
        killed    = (flc >= 1) && (flc < e_cyc);
        last      = killed ? ((rdy > flc) ? rdy + 1 : flc + 1) : e_cyc;
        exp_rd    = exc ? 5'd30 : rd;
        exp_data  = exc ? (eff_div ? 32'd5 : 32'd4) : res;

        for (int c = 0; c <= last; c++) begin
            idle_inputs();
            if (c == 0) begin
                ex_is_mult = !is_div || both;
                ex_is_div  = is_div || both;
                ex_opA     = a;
                ex_opB     = b;
                ex_rd      = rd;
            end
            flush = (c == flc);
            if (c == rdy) begin
                mdif.md_ready     = 1'b1;
                mdif.md_result    = res;
                mdif.md_exception = mexc;
            end
            @(negedge clock);
            p = $sformatf("op%0d c%0d", op_id, c);
            if (killed) check({p, " stall"}, 32'(stall), 32'(c <= flc));
            else        check({p, " stall"}, 32'(stall), 32'(c < e_cyc));
            check({p, " ctrlM"}, 32'(mdif.ctrl_MULT), 32'(c == 1 && !eff_div));
            check({p, " ctrlD"}, 32'(mdif.ctrl_DIV),  32'(c == 1 && eff_div));
            check({p, " wbv"}, 32'(wb_valid),
                  32'(!killed && c == e_cyc && (exc || rd != 0) && flc != e_cyc));
            if (c == 1 || (!killed && c == e_cyc)) begin
                check({p, " opA"}, mdif.md_opA, a);
                check({p, " opB"}, mdif.md_opB, b);
            end
            if (!killed && c == e_cyc && wb_valid) begin
                check({p, " wbrd"},   32'(wb_rd), 32'(exp_rd));
                check({p, " wbdata"}, wb_data, exp_data);
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // MUL 7*6 rd=3, ready 17 cycles after the pulse
        run_op(0, 0, 32'd7, 32'd6, 5'd3, 18, 0, -1);
        // DIV by zero with exception, then MUL overflow
        run_op(1, 0, 32'd100, 32'd0, 5'd9, 10, 1, -1);
        run_op(0, 0, 32'h0001_0000, 32'h0001_0000, 5'd2, 6, 1, -1);
        // multdiv never answers: forced MUL exception
        run_op(0, 0, 32'd3, 32'd5, 5'd8, -1, 0, -1);
        // flush in BUSY, later ready ignored
        run_op(0, 0, 32'd11, 32'd13, 5'd4, 17, 0, 6);
        // flush on the DONE cycle, flush with ready same cycle, flush in START
        run_op(1, 0, 32'd50, 32'd7, 5'd6, 5, 0, 6);
        run_op(0, 0, 32'd2, 32'd9, 5'd6, 8, 0, 8);
        run_op(1, 0, 32'd40, 32'd8, 5'd1, 4, 0, 1);
        // rd=0 suppressed, then back-to-back DIV 9/3
        run_op(0, 0, 32'd3, 32'd4, 5'd0, 5, 0, -1);
        run_op(1, 0, 32'd9, 32'd3, 5'd4, 7, 0, -1);
        // both op bits -> MUL; ready during START is ignored
        run_op(1, 1, 32'd6, 32'd7, 5'd5, 4, 0, -1);
        run_op(1, 0, 32'd20, 32'd0, 5'd5, 1, 0, -1);

        // flush in IDLE blocks the issue
        idle_inputs();
        ex_is_mult = 1'b1;
        flush      = 1'b1;
        @(negedge clock);
        check("idleflush stall0", 32'(stall), 1);
        @(posedge clock);
        #1;
        idle_inputs();
        @(negedge clock);
        check("idleflush stall1", 32'(stall), 0);
        check("idleflush ctrlM",  32'(mdif.ctrl_MULT), 0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 25; i++) begin
            bit          r_div;
            bit          r_both;
            logic [31:0] ra;
            logic [31:0] rb;
            int          rrdy;
            int          rfl;
            r_div  = 1'($urandom);
            r_both = ($urandom_range(0, 7) == 0);
            ra     = $urandom_range(0, 5000);
            rb     = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 300);
            rrdy   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 45);
            rfl    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 44) : -1;
            run_op(r_div, r_both, ra, rb, 5'($urandom), rrdy,
                   (r_div && !r_both && rb == 0) ? 1'b1 : ($urandom_range(0, 5) == 0), rfl);
        end

        // asynchronous reset in the middle of BUSY
        idle_inputs();
        ex_is_mult = 1'b1;
        ex_opA     = 32'd5;
        ex_opB     = 32'd5;
        ex_rd      = 5'd7;
        @(posedge clock);
        #1;
        idle_inputs();
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clock);
        #1;
        reset_n           = 1'b1;
        mdif.md_ready     = 1'b1;
        mdif.md_result    = 32'd25;
        mdif.md_exception = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check($sformatf("postreset c%0d stall", c), 32'(stall), 0);
            check($sformatf("postreset c%0d wbv", c), 32'(wb_valid), 0);
            @(posedge clock);
            #1;
            idle_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
